// File: rtl/operand_demux_loader.sv
// Sequential 1-to-3 demux: steers Dato into A, B, then OP on successive Cargar presses.
// Optional input debounce filter is enabled by defining DEBOUNCE_EN.
module operand_demux_loader #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned OPW        = 4,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Dato,
  input  logic             Cargar,
  input  logic             Cancelar,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OPW-1:0]   OP,
  output logic [1:0]       Estado,
  output logic             Listo,
  output logic             Nuevo,
  output logic             SEL
);

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_LISTO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, fq_q, f;
  logic [1:0]       prime_q;
  logic             armed_q, armed_d;
  logic             ev;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             nuevo_q, nuevo_d;

`ifdef DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          f_q, f_d;

  always_comb begin
    f_d   = f_q;
    cnt_d = '0;
    if (s2_q != f_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        f_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f = f_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign f          = s2_q;
`endif

  // Events stay blocked after reset until the conditioned button has been seen low,
  // so a button held through reset needs a fresh press.
  always_comb begin
    armed_d = armed_q | (prime_q[1] & ~s1_q & ~s2_q & ~f);
    ev      = armed_q & f & ~fq_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    nuevo_d = 1'b0;
    if (Cancelar) begin
      state_d = S_A;
    end else if (ev) begin
      unique case (state_q)
        S_A: begin
          a_d     = Dato;
          state_d = S_B;
        end
        S_B: begin
          b_d     = Dato;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = Dato[OPW-1:0];
          state_d = S_LISTO;
          nuevo_d = 1'b1;
        end
        S_LISTO: begin
          state_d = S_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      fq_q    <= 1'b0;
      prime_q <= '0;
      armed_q <= 1'b0;
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      nuevo_q <= 1'b0;
    end else begin
      s1_q    <= Cargar;
      s2_q    <= s1_q;
      fq_q    <= f;
      prime_q <= {prime_q[0], 1'b1};
      armed_q <= armed_d;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      nuevo_q <= nuevo_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign OP     = op_q;
  assign Estado = state_q;
  assign Listo  = (state_q == S_LISTO);
  assign SEL    = (state_q == S_LISTO);
  assign Nuevo  = nuevo_q;

endmodule

// File: tb/tb_operand_demux_loader.sv
// Scoreboard bench for operand_demux_loader; expected state/register snapshots are
// queued at stimulus time and checked by a monitor whenever Estado changes.
module tb_operand_demux_loader;

  localparam int WIDTH = 6;
  localparam int OPW   = 4;
  localparam int DEB   = 16;
`ifdef DEBOUNCE_EN
  localparam int LAT  = 2 + DEB;
  localparam int HOLD = 30;
`else
  localparam int LAT  = 2;
  localparam int HOLD = 4;
`endif

  logic             clk = 1'b0;
  logic             rst, Cargar, Cancelar;
  logic [WIDTH-1:0] Dato;
  logic [WIDTH-1:0] A, B;
  logic [OPW-1:0]   OP;
  logic [1:0]       Estado;
  logic             Listo, Nuevo, SEL;

  operand_demux_loader #(.WIDTH(WIDTH), .OPW(OPW), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .Dato(Dato), .Cargar(Cargar), .Cancelar(Cancelar),
    .A(A), .B(B), .OP(OP), .Estado(Estado), .Listo(Listo), .Nuevo(Nuevo), .SEL(SEL)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int st;
    int a;
    int b;
    int op;
    int nu;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Estado change must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Estado !== prev_st) begin
        if (sb.size() == 0) begin
          chk("unexpected_transition", 32'(Estado), 32'(prev_st));
          chk("nuevo_idle", 32'(Nuevo), 0);
        end else begin
          e = sb.pop_front();
          chk("when",   cyc,          e.cyc);
          chk("estado", 32'(Estado),  e.st);
          chk("A",      32'(A),       e.a);
          chk("B",      32'(B),       e.b);
          chk("OP",     32'(OP),      e.op);
          chk("listo",  32'(Listo),   (e.st == 3) ? 1 : 0);
          chk("sel",    32'(SEL),     (e.st == 3) ? 1 : 0);
          chk("nuevo",  32'(Nuevo),   e.nu);
        end
      end else begin
        chk("nuevo_idle", 32'(Nuevo), 0);
      end
    end
    prev_st = Estado;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [WIDTH-1:0] d, input int hi, input int lo,
                       input int st, input int a, input int b, input int op, input int nu);
    Dato   = d;
    Cargar = 1'b1;
    sb.push_back('{cyc + 1 + LAT, st, a, b, op, nu});
    step(hi);
    Cargar = 1'b0;
    step(lo);
  endtask

  initial begin
    rst      = 1'b1;
    Cargar   = 1'b1;
    Cancelar = 1'b0;
    Dato     = '0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_A",      32'(A),      0);
    chk("rst_B",      32'(B),      0);
    chk("rst_OP",     32'(OP),     0);
    chk("rst_estado", 32'(Estado), 0);
    chk("rst_listo",  32'(Listo),  0);
    chk("rst_nuevo",  32'(Nuevo),  0);
    chk("rst_sel",    32'(SEL),    0);
    mon_en = 1'b1;
    step(1);

    // Button held through reset: no event may appear until a fresh press.
    step(10);
    Cargar = 1'b0;
    step(HOLD);

    press(6'd9,  HOLD, HOLD, 1, 9, 0,  0, 0);
    press(6'd22, HOLD, HOLD, 2, 9, 22, 0, 0);
    press(6'd5,  HOLD, HOLD, 3, 9, 22, 5, 1);
    press(6'd7,  HOLD, HOLD, 0, 9, 22, 5, 0);

    press(6'd9,  HOLD, HOLD, 1, 9, 22, 5, 0);
    press(6'd22, HOLD, HOLD, 2, 9, 22, 5, 0);
    Cancelar = 1'b1;
    sb.push_back('{cyc + 1, 0, 9, 22, 5, 0});
    step(1);
    Cancelar = 1'b0;
    step(4);

    // Cancel lands on the would-be capture edge of B.
    press(6'd9, HOLD, HOLD, 1, 9, 22, 5, 0);
    Dato   = 6'd44;
    Cargar = 1'b1;
    sb.push_back('{cyc + 1 + LAT, 0, 9, 22, 5, 0});
    step(LAT);
    Cancelar = 1'b1;
    step(1);
    Cancelar = 1'b0;
    step(HOLD);
    Cargar = 1'b0;
    step(HOLD);

    press(6'd63, 50, HOLD, 1, 63, 22, 5, 0);

`ifndef DEBOUNCE_EN
    // Two presses at minimum spacing: captures two edges apart.
    Dato   = 6'd11;
    Cargar = 1'b1;
    sb.push_back('{cyc + 3, 2, 63, 11, 5,  0});
    sb.push_back('{cyc + 5, 3, 63, 11, 13, 1});
    step(1);
    Cargar = 1'b0;
    step(1);
    Cargar = 1'b1;
    step(1);
    Dato   = 6'd13;
    Cargar = 1'b0;
    step(4);
    press(6'd0, HOLD, HOLD, 0, 63, 11, 13, 0);
`else
    Cargar = 1'b1;
    step(10);
    Cargar = 1'b0;
    step(HOLD);
    press(6'd1, 30, 30, 2, 63, 1, 5, 0);
    for (int i = 0; i < 8; i++) begin
      Cargar = 1'b1;
      step(3);
      Cargar = 1'b0;
      step(3);
    end
    step(HOLD);
`endif

    step(5);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_demux_loader.md
# operand_demux_loader

Sequential 1-to-3 demultiplexer. It steers the shared switch bus `Dato` into the ALU operand registers A and B and the opcode register OP, one load strobe at a time. It sits between the board switches/button and the ALU datapath. It also drives the `SEL` line of the downstream 2:1 display mux, so the live switch value is shown while loading and the ALU result is shown once all three registers are loaded.

## Interface
- `WIDTH`, 6: width of `Dato`, `A`, `B`.
- `OPW`, 4: width of `OP`; taken from `Dato[OPW-1:0]`.
- `DEB_CYCLES`, 16: debounce stability window in clocks. Used only with `DEBOUNCE_EN`.
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `Dato`, in, WIDTH: switch bus. The user holds it stable while pressing `Cargar`. It is not synchronized.
- `Cargar`, in, 1: load button, asynchronous level.
- `Cancelar`, in, 1: synchronous abort back to loading A. Already synchronous to `clk`.
- `A`, out, WIDTH: operand A register.
- `B`, out, WIDTH: operand B register.
- `OP`, out, OPW: opcode register.
- `Estado`, out, 2: current state. 0 = S_A, 1 = S_B, 2 = S_OP, 3 = S_LISTO.
- `Listo`, out, 1: high while in S_LISTO.
- `Nuevo`, out, 1: one-cycle pulse on entry to S_LISTO.
- `SEL`, out, 1: display mux select. 0 shows `Dato`; 1 shows the result. Equal to `Listo`.

## Operation
- **Reset:** `A`=0, `B`=0, `OP`=0, `Estado`=0 (S_A), `Listo`=0, `Nuevo`=0, `SEL`=0. The synchronizer and debounce state are also cleared to 0.
- **Input conditioning:** `Cargar` passes through a 2-flop synchronizer (s1, s2). It then goes through the optional debounce filter (producing f; without debounce, f = s2) and a delay flop (fq).
- **Load event:** `ev = f & ~fq`. There is exactly one event per press. A held button produces no repeats.
- **State transitions on `ev`:**
  - S_A: `A <= Dato`; go to S_B.
  - S_B: `B <= Dato`; go to S_OP.
  - S_OP: `OP <= Dato[OPW-1:0]`; go to S_LISTO; `Nuevo` pulses.
  - S_LISTO: no register capture; go to S_A. `A`, `B` and `OP` keep their old values until overwritten.
- **No event:** the state holds and all registers hold.
- **`Cancelar`:** forces S_A on the next edge from any state and clears `Listo`. It does not alter `A`, `B` or `OP`.
- **`Cancelar` and `ev` in the same cycle:** `Cancelar` wins and no capture occurs.
- **`Nuevo`:** high for exactly the one cycle after the S_OP→S_LISTO edge. It is never high in any other state.
- **`rst` mid-sequence:** the block returns to reset values on the next edge, including a pending edge-detect. A button held through reset does not generate an event after release of `rst`; a fresh press is required.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- **Without debounce:** if `Cargar` is first sampled high at edge k, `ev` is high during the cycle after edge k+1. The capture and state change occur at edge k+2, and `Dato` is sampled at edge k+2.
- **With debounce:** the capture occurs at edge k+2+DEB_CYCLES.
- `Listo`/`SEL` rise at the same edge as the OP capture. `Nuevo` is high for the following cycle only.
- Minimum spacing between accepted presses is 2 clocks without debounce (`f` must fall and rise again).

## Configuration
- **`DEBOUNCE_EN` defined:**
  - A counter (width `$clog2(DEB_CYCLES+1)`) compares s2 with f.
  - f toggles only after s2 differs from f for DEB_CYCLES consecutive edges.
  - Any return of s2 to equal f resets the counter to 0.
  - Glitches shorter than DEB_CYCLES clocks are ignored.
- **`DEBOUNCE_EN` undefined:** f = s2. There is no counter or debounce logic, and `DEB_CYCLES` is unused.

## Test plan
- **Reset:** hold `rst` for 3 clocks with `Cargar`=1 → all outputs 0 and `Estado`=0. No event after `rst` falls until `Cargar` goes 0 then 1.
- **Full load, without debounce:** presses (each 4 clocks high, 4 low) with `Dato`=9, then 6'd22, then 6'd5 → `A`=9, `B`=22, `OP`=5.
  - `Listo`=`SEL`=1 and `Nuevo` is a single 1-cycle pulse.
  - Each capture lands exactly 2 edges after the first high sample.
- **Held button:** `Cargar` held high for 50 clocks in S_A with `Dato`=6'd63 → `A`=63 and `Estado`=1. No further transitions.
- **Cancel and wrap:**
  - `Cancelar` in S_OP (A=9, B=22) → `Estado`=0 with `A`/`B` unchanged.
  - `Cancelar` and `ev` in the same cycle → no capture.
  - A press in S_LISTO → S_A with `A` still 9.
- **Debounce (`DEBOUNCE_EN` defined, DEB_CYCLES=16):**
  - A 10-clock `Cargar` pulse → no event.
  - A 30-clock pulse → exactly one capture at edge k+18.
  - A bounce pattern of 1/0 alternating every 3 clocks → no event.
